regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 80 ++++++++
 tb/tb_regfile_sb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port,
// N/Z/P condition codes and a per-register pending-write scoreboard.
module regfile_sb #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic             rd_a_busy,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_b_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ld_cc,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic [2:0]       cc,
    output logic [DEPTH-1:0] busy
);

    localparam bit BYP_EN = (BYPASS != 0);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [2:0]       cc_q, cc_d;
    logic             wr_neg, wr_zero;
    logic             hit_a, hit_b;

    assign wr_neg  = wr_data[WIDTH-1];
    assign wr_zero = (wr_data == '0);

    // Next-state: writeback, condition codes, scoreboard (issue set beats writeback clear)
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        cc_d   = cc_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
            if (ld_cc) begin
                cc_d = {wr_neg, wr_zero, ~wr_neg & ~wr_zero};
            end
        end
        if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // State registers; reset clears data and scoreboard, cc resets to Z
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            cc_q   <= 3'b010;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cc_q   <= cc_d;
        end
    end

    // Read ports with optional same-cycle write forwarding
    assign hit_a     = BYP_EN && wr_en && (wr_addr == rd_a_addr);
    assign hit_b     = BYP_EN && wr_en && (wr_addr == rd_b_addr);
    assign rd_a_data = hit_a ? wr_data : regs_q[rd_a_addr];
    assign rd_b_data = hit_b ? wr_data : regs_q[rd_b_addr];
    assign rd_a_busy = busy_q[rd_a_addr] & ~hit_a;
    assign rd_b_busy = busy_q[rd_b_addr] & ~hit_b;

    assign cc   = cc_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default, no-bypass and 16x32 instances against a
// behavioural model, with directed steps followed by random traffic.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    // Stimulus shared by the 8x16 instances (bypass on / off)
    logic [2:0]  a_rda, a_rdb, a_waddr, a_issaddr;
    logic [15:0] a_wdata;
    logic        a_wen, a_ldcc, a_iss;
    // Stimulus for the 16x32 instance
    logic [3:0]  b_rda, b_rdb, b_waddr, b_issaddr;
    logic [31:0] b_wdata;
    logic        b_wen, b_ldcc, b_iss;

    logic [15:0] u0_rda, u0_rdb, u1_rda, u1_rdb;
    logic        u0_ba, u0_bb, u1_ba, u1_bb, u2_ba, u2_bb;
    logic [2:0]  u0_cc, u1_cc, u2_cc;
    logic [7:0]  u0_busy, u1_busy;
    logic [31:0] u2_rda, u2_rdb;
    logic [15:0] u2_busy;

    regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .rd_a_addr(a_rda), .rd_a_data(u0_rda), .rd_a_busy(u0_ba),
        .rd_b_addr(a_rdb), .rd_b_data(u0_rdb), .rd_b_busy(u0_bb),
        .wr_en(a_wen), .wr_addr(a_waddr), .wr_data(a_wdata), .ld_cc(a_ldcc),
        .iss_en(a_iss), .iss_addr(a_issaddr), .cc(u0_cc), .busy(u0_busy));

    regfile_sb #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rd_a_addr(a_rda), .rd_a_data(u1_rda), .rd_a_busy(u1_ba),
        .rd_b_addr(a_rdb), .rd_b_data(u1_rdb), .rd_b_busy(u1_bb),
        .wr_en(a_wen), .wr_addr(a_waddr), .wr_data(a_wdata), .ld_cc(a_ldcc),
        .iss_en(a_iss), .iss_addr(a_issaddr), .cc(u1_cc), .busy(u1_busy));

    regfile_sb #(.WIDTH(32), .DEPTH(16), .BYPASS(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .rd_a_addr(b_rda), .rd_a_data(u2_rda), .rd_a_busy(u2_ba),
        .rd_b_addr(b_rdb), .rd_b_data(u2_rdb), .rd_b_busy(u2_bb),
        .wr_en(b_wen), .wr_addr(b_waddr), .wr_data(b_wdata), .ld_cc(b_ldcc),
        .iss_en(b_iss), .iss_addr(b_issaddr), .cc(u2_cc), .busy(u2_busy));

    // Reference model state
    logic [15:0] ma_regs [8];
    logic [7:0]  ma_busy;
    logic [2:0]  ma_cc;
    logic [31:0] mb_regs [16];
    logic [15:0] mb_busy;
    logic [2:0]  mb_cc;

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [2:0] cc_of(input bit neg, input bit zero);
        if (neg) return 3'b100;
        if (zero) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [15:0] ea_rd(input logic [2:0] ad, input bit byp);
        return (byp && a_wen && a_waddr == ad) ? a_wdata : ma_regs[ad];
    endfunction
    function automatic logic ea_bz(input logic [2:0] ad, input bit byp);
        return ma_busy[ad] && !(byp && a_wen && a_waddr == ad);
    endfunction
    function automatic logic [31:0] eb_rd(input logic [3:0] ad);
        return (b_wen && b_waddr == ad) ? b_wdata : mb_regs[ad];
    endfunction
    function automatic logic eb_bz(input logic [3:0] ad);
        return mb_busy[ad] && !(b_wen && b_waddr == ad);
    endfunction

    task automatic model_reset();
        foreach (ma_regs[i]) ma_regs[i] = '0;
        foreach (mb_regs[i]) mb_regs[i] = '0;
        ma_busy = '0;
        mb_busy = '0;
        ma_cc   = 3'b010;
        mb_cc   = 3'b010;
    endtask

    // Apply one clock edge's worth of architectural effect to the model
    task automatic model_edge();
        logic [7:0]  clr_a, set_a;
        logic [15:0] clr_b, set_b;
        if (!rst_n) begin
            model_reset();
            return;
        end
        clr_a = a_wen ? (8'd1 << a_waddr) : 8'd0;
        set_a = a_iss ? (8'd1 << a_issaddr) : 8'd0;
        clr_b = b_wen ? (16'd1 << b_waddr) : 16'd0;
        set_b = b_iss ? (16'd1 << b_issaddr) : 16'd0;
        ma_busy = (ma_busy & ~clr_a) | set_a;
        mb_busy = (mb_busy & ~clr_b) | set_b;
        if (a_wen) ma_regs[a_waddr] = a_wdata;
        if (b_wen) mb_regs[b_waddr] = b_wdata;
        if (a_wen && a_ldcc) ma_cc = cc_of(a_wdata[15], a_wdata == 16'd0);
        if (b_wen && b_ldcc) mb_cc = cc_of(b_wdata[31], b_wdata == 32'd0);
    endtask

    task automatic check_comb();
        chk("u0_rd_a", 32'(u0_rda), 32'(ea_rd(a_rda, 1'b1)));
        chk("u0_rd_b", 32'(u0_rdb), 32'(ea_rd(a_rdb, 1'b1)));
        chk("u0_bz_a", 32'(u0_ba), 32'(ea_bz(a_rda, 1'b1)));
        chk("u0_bz_b", 32'(u0_bb), 32'(ea_bz(a_rdb, 1'b1)));
        chk("u1_rd_a", 32'(u1_rda), 32'(ea_rd(a_rda, 1'b0)));
        chk("u1_rd_b", 32'(u1_rdb), 32'(ea_rd(a_rdb, 1'b0)));
        chk("u1_bz_a", 32'(u1_ba), 32'(ea_bz(a_rda, 1'b0)));
        chk("u1_bz_b", 32'(u1_bb), 32'(ea_bz(a_rdb, 1'b0)));
        chk("u2_rd_a", u2_rda, eb_rd(b_rda));
        chk("u2_rd_b", u2_rdb, eb_rd(b_rdb));
        chk("u2_bz_a", 32'(u2_ba), 32'(eb_bz(b_rda)));
        chk("u2_bz_b", 32'(u2_bb), 32'(eb_bz(b_rdb)));
    endtask

    task automatic check_seq();
        chk("u0_cc", 32'(u0_cc), 32'(ma_cc));
        chk("u1_cc", 32'(u1_cc), 32'(ma_cc));
        chk("u2_cc", 32'(u2_cc), 32'(mb_cc));
        chk("u0_busy", 32'(u0_busy), 32'(ma_busy));
        chk("u1_busy", 32'(u1_busy), 32'(ma_busy));
        chk("u2_busy", 32'(u2_busy), 32'(mb_busy));
    endtask

    // One clock: comb checks mid-cycle, model edge, registered checks just after
    task automatic cycle();
        @(negedge clk);
        check_comb();
        @(posedge clk);
        model_edge();
        #1;
        check_seq();
    endtask

    task automatic idle();
        a_wen = 0; a_ldcc = 0; a_iss = 0;
        b_wen = 0; b_ldcc = 0; b_iss = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_rda = 0; a_rdb = 0; a_waddr = 0; a_issaddr = 0; a_wdata = 0;
        b_rda = 0; b_rdb = 0; b_waddr = 0; b_issaddr = 0; b_wdata = 0;
        idle();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_seq();
        rst_n = 1'b1;

        // Write 0x8001 to r3 with cc load
        a_wen = 1; a_ldcc = 1; a_waddr = 3; a_wdata = 16'h8001; a_rda = 3;
        cycle();
        chk("cc_neg", 32'(u0_cc), 32'h4);
        idle(); a_rda = 3;
        cycle();
        chk("r3_read", 32'(u0_rda), 32'h8001);
        a_wen = 1; a_ldcc = 1; a_waddr = 4; a_wdata = 16'h0000;
        cycle();
        chk("cc_zero", 32'(u0_cc), 32'h2);

        // Bypass on r5
        idle(); a_wen = 1; a_waddr = 5; a_wdata = 16'h1234; a_rdb = 5;
        @(negedge clk);
        chk("byp_on", 32'(u0_rdb), 32'h1234);
        chk("byp_off", 32'(u1_rdb), 32'h0000);
        @(posedge clk); model_edge(); #1; check_seq();

        // Scoreboard on r2
        idle(); a_iss = 1; a_issaddr = 2; a_rda = 2;
        cycle();
        chk("busy_iss2", 32'(u0_busy), 32'h04);
        idle(); a_rda = 2;
        @(negedge clk);
        chk("rda_busy2", 32'(u0_ba), 32'h1);
        @(posedge clk); model_edge(); #1;
        a_wen = 1; a_waddr = 2; a_wdata = 16'h00aa;
        @(negedge clk);
        chk("rda_busy_byp", 32'(u0_ba), 32'h0);
        chk("rda_busy_nobyp", 32'(u1_ba), 32'h1);
        @(posedge clk); model_edge(); #1;
        chk("busy_clr2", 32'(u0_busy), 32'h00);

        // Issue and writeback together on r6, then split r1/r6
        idle(); a_wen = 1; a_waddr = 6; a_wdata = 16'h6666; a_iss = 1; a_issaddr = 6;
        cycle();
        chk("busy6_held", 32'(u0_busy), 32'h40);
        idle(); a_rda = 6;
        cycle();
        chk("r6_data", 32'(u0_rda), 32'h6666);
        a_wen = 1; a_waddr = 6; a_wdata = 16'h0606; a_iss = 1; a_issaddr = 1;
        cycle();
        chk("busy_split", 32'(u0_busy), 32'h02);

        // 16x32: r15 all ones
        idle(); b_wen = 1; b_ldcc = 1; b_waddr = 15; b_wdata = 32'hFFFF_FFFF;
        cycle();
        chk("w32_cc", 32'(u2_cc), 32'h4);
        idle();
        for (int k = 0; k < 8; k++) begin
            b_rda = 4'(2 * k); b_rdb = 4'(2 * k + 1);
            cycle();
        end
        b_rda = 15;
        @(negedge clk);
        chk("w32_r15", u2_rda, 32'hFFFF_FFFF);
        @(posedge clk); model_edge(); #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            a_rda = 3'($urandom); a_rdb = 3'($urandom);
            a_wen = 1'($urandom); a_ldcc = 1'($urandom); a_iss = 1'($urandom);
            a_waddr = 3'($urandom); a_issaddr = 3'($urandom);
            a_wdata = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            b_rda = 4'($urandom); b_rdb = 4'($urandom);
            b_wen = 1'($urandom); b_ldcc = 1'($urandom); b_iss = 1'($urandom);
            b_waddr = 4'($urandom); b_issaddr = 4'($urandom);
            b_wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cycle();
        end

        // Mid-cycle reset with a write and issue pending on the same edge
        @(negedge clk);
        a_wen = 1; a_ldcc = 1; a_waddr = 7; a_wdata = 16'h8000; a_iss = 1; a_issaddr = 7;
        b_wen = 1; b_ldcc = 1; b_waddr = 15; b_wdata = 32'h8000_0000; b_iss = 1; b_issaddr = 15;
        a_rda = 0; a_rdb = 1; b_rda = 0; b_rdb = 1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 32'(u0_busy), 32'h0);
        chk("rst_cc", 32'(u0_cc), 32'h2);
        check_seq();
        for (int k = 0; k < 8; k++) begin
            a_rda = 3'(2 * k); a_rdb = 3'(2 * k + 1);
            b_rda = 4'(2 * k); b_rdb = 4'(2 * k + 1);
            #1;
            check_comb();
        end
        @(posedge clk); model_edge(); #1;
        check_seq();
        rst_n = 1'b1;

        // First edge after reset release does a normal update
        a_wen = 1; a_ldcc = 1; a_waddr = 7; a_wdata = 16'h0005; a_iss = 1; a_issaddr = 0;
        b_wen = 1; b_ldcc = 1; b_waddr = 3; b_wdata = 32'h0000_0009; b_iss = 0;
        cycle();
        chk("post_rst_cc", 32'(u0_cc), 32'h1);
        idle(); a_rda = 7;
        cycle();
        chk("post_rst_r7", 32'(u1_rda), 32'h0005);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
